result_scoreboard: RTL and testbench
====================================

# result_scoreboard

Sequencing end of the 32-bit result comparison path: pairs each DUT result with the next stored golden value, presents the pair to a `compare` instance, and consumes its `match` output. Accumulates checked/error counts and the first-failure index over a run of `NUM_VECTORS` results, then reports pass/fail. Sits between the golden-vector source, the DUT result stream and the comparator in the homework test harnesses.

## Interface

- `WIDTH`, 32, data width of results and golden values.
- `DEPTH`, 8, golden FIFO entries; must be a power of 2, ≥2.
- `NUM_VECTORS`, 16, results per run; must be 1..2^`CNT_W`-1.
- `CNT_W`, 16, width of the count and index outputs.

One clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `gold_valid`  in  1  golden value offered.
- `gold_ready`  out  1  FIFO can accept a golden value.
- `gold_data`  in  `WIDTH`  golden value.
- `res_valid`  in  1  DUT result offered.
- `res_ready`  out  1  block accepts a DUT result.
- `res_data`  in  `WIDTH`  DUT result.
- `test_result`  out  `WIDTH`  registered DUT result to the comparator.
- `gold_result`  out  `WIDTH`  registered golden value to the comparator.
- `cmp_valid`  out  1  the presented pair is valid this cycle.
- `match`  in  1  combinational comparator result for the presented pair.
- `busy`  out  1  run in progress (RUN or CHECK).
- `done`  out  1  run complete (DONE state).
- `pass`  out  1  `done` and `error_count` == 0.
- `checked_count`  out  `CNT_W`  results checked this run.
- `error_count`  out  `CNT_W`  mismatches this run; saturates at all-ones.
- `first_err_valid`  out  1  at least one mismatch this run.
- `first_err_idx`  out  `CNT_W`  0-based index of the first mismatching result.

## Operation

- **Golden FIFO:** `DEPTH` entries.
  - A push occurs when `gold_valid && gold_ready`; `gold_ready` = !full, evaluated from the current occupancy only. A pop in the same cycle does not allow a push while full.
  - Accepts pushes in every state. It is cleared only by `reset`, not by `start`, so goldens may be preloaded.
- **FSM states:** IDLE, RUN, CHECK, DONE.
- **IDLE:**
  - `res_ready`=0.
  - When `start`=1, clear `checked_count`, `error_count`, `first_err_valid` and `first_err_idx`, then go to RUN.
- **RUN:**
  - `res_ready` = FIFO non-empty.
  - On `res_valid && res_ready`: `test_result`←`res_data` and `gold_result`←FIFO head, pop the FIFO, go to CHECK.
- **CHECK:**
  - `cmp_valid`=1 and `res_ready`=0. Sample `match` at the end of the cycle.
  - `checked_count`+1.
  - If `match`=0: `error_count`+1 (saturating). If `first_err_valid`=0, set it and load `first_err_idx`←`checked_count` (the pre-increment value).
  - Next state: DONE if the new `checked_count` == `NUM_VECTORS`, otherwise RUN.
- **DONE:**
  - `done`=1; `pass` = (`error_count`==0).
  - Counters and the comparator pair hold.
  - When `start`=1, clear the counters and go to RUN; FIFO contents are retained.
- `start` is ignored in RUN and CHECK.
- `test_result` and `gold_result` hold their last values outside CHECK; consumers must qualify them with `cmp_valid`.
- `match` is ignored whenever `cmp_valid`=0.

## Timing

- Reset values:
  - State IDLE; FIFO empty.
  - `gold_ready`=1, `res_ready`=0, `cmp_valid`=0, `busy`=0, `done`=0, `pass`=0.
  - All counts, `first_err_idx`, `first_err_valid`, `test_result` and `gold_result` = 0.
- Result handshake at edge N → `cmp_valid`=1 during cycle N+1. Counters show the update after edge N+2.
- Throughput: at most one result per 2 cycles.
- Golden push at edge N → entry is poppable from cycle N+1.
- Last CHECK → `done`=1 in the following cycle.
- `reset` asserted in any state, including mid-run or with the FIFO partly full, returns everything to reset values at the next edge.

## Test plan

- **Reset mid-run:** preload 4 goldens, start, assert `reset` after 2 results → FIFO empty, all outputs at reset values, `gold_ready`=1.
- **All match:** preload goldens 0..15, start, feed results 0..15 with the comparator attached → `done`=1, `pass`=1, `checked_count`=16, `error_count`=0, `first_err_valid`=0.
- **Mismatches:** as above, but results 3 and 9 are replaced by 32'hFFFFFFFF → `error_count`=2, `first_err_idx`=3, `pass`=0.
- **Backpressure:** FIFO empty in RUN with `res_valid`=1 → `res_ready`=0 and no state change. Push one golden → the result is accepted the next cycle.
- **FIFO full:** push 8 goldens in IDLE with `DEPTH`=8 → `gold_ready`=0. A 9th push is held until a pop, then accepted with the value intact and order preserved.
- **Restart:** after DONE, pulse `start` with 16 new goldens → counters clear to 0 in the cycle after `start`. `start` asserted during RUN has no effect.

Source files
------------

// File: rtl/result_scoreboard_if.sv
// rtl/result_scoreboard_if.sv - golden, DUT result and comparator handshakes of result_scoreboard
interface result_scoreboard_if #(
    parameter int WIDTH = 32
);
    logic             gold_valid;
    logic             gold_ready;
    logic [WIDTH-1:0] gold_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] test_result;
    logic [WIDTH-1:0] gold_result;
    logic             cmp_valid;
    logic             match;

    modport master (
        output gold_valid, gold_data, res_valid, res_data, match,
        input  gold_ready, res_ready, test_result, gold_result, cmp_valid
    );

    modport slave (
        input  gold_valid, gold_data, res_valid, res_data, match,
        output gold_ready, res_ready, test_result, gold_result, cmp_valid
    );
endinterface

// File: rtl/result_scoreboard.sv
// rtl/result_scoreboard.sv - pairs DUT results with stored goldens, counts checks and mismatches
module result_scoreboard #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    result_scoreboard_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   checked_count,
    output logic [CNT_W-1:0]   error_count,
    output logic               first_err_valid,
    output logic [CNT_W-1:0]   first_err_idx
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push;
    logic             take, clear_cnt, res_ready_c, cmp_valid_c;
    logic [WIDTH-1:0] test_q, gold_q;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.gold_valid && !full;

    assign bus.gold_ready  = !full;
    assign bus.res_ready   = res_ready_c;
    assign bus.cmp_valid   = cmp_valid_c;
    assign bus.test_result = test_q;
    assign bus.gold_result = gold_q;

    assign busy = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done = (state_q == S_DONE);
    assign pass = done && (error_count == '0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        res_ready_c = 1'b0;
        cmp_valid_c = 1'b0;
        take        = 1'b0;
        clear_cnt   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clear_cnt = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                res_ready_c = !empty;
                if (bus.res_valid && !empty) begin
                    take    = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cmp_valid_c = 1'b1;
                // checked_count still holds the pre-increment value here.
                state_d = (checked_count == CNT_W'(NUM_VECTORS - 1)) ? S_DONE : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.gold_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            test_q          <= '0;
            gold_q          <= '0;
            checked_count   <= '0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (take) begin
                rd_ptr <= rd_ptr + 1'b1;
                test_q <= bus.res_data;
                gold_q <= mem[rd_ptr[AW-1:0]];
            end
            if (clear_cnt) begin
                checked_count   <= '0;
                error_count     <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
            end else if (cmp_valid_c) begin
                checked_count <= checked_count + 1'b1;
                if (!bus.match) begin
                    if (error_count != '1) error_count <= error_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= checked_count;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_result_scoreboard.sv
// tb/tb_result_scoreboard.sv - randomized scoreboard bench for result_scoreboard
module tb_result_scoreboard;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int NV = 16;
    localparam int CW = 16;

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] g;
    } pair_t;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, pass, first_err_valid;
    logic [CW-1:0] checked_count, error_count, first_err_idx;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] gq[$];
    pair_t        exq[$];
    int           run_idx = 0;
    int           run_err = 0;

    always #5 clk = ~clk;

    result_scoreboard_if #(.WIDTH(W)) bus();

    // Stand-in for the external compare instance.
    assign bus.match = (bus.test_result == bus.gold_result);

    result_scoreboard #(.WIDTH(W), .DEPTH(D), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass),
        .checked_count(checked_count), .error_count(error_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (!reset && bus.cmp_valid) begin
            if (exq.size() == 0) begin
                check("cmp_unexpected", 1, 0);
            end else begin
                p = exq.pop_front();
                check("cmp_test_result", bus.test_result, p.t);
                check("cmp_gold_result", bus.gold_result, p.g);
                check("cmp_checked_pre", checked_count, run_idx);
                check("cmp_errors_pre", error_count, run_err);
                if (p.t != p.g) run_err++;
                run_idx++;
            end
        end
    end

    task automatic push_gold(input logic [W-1:0] v);
        bus.gold_valid = 1'b1;
        bus.gold_data  = v;
        for (int k = 0; k < 300; k++) begin
            if (bus.gold_ready) begin
                if (gq.size() >= D) check("gold_ready_when_full", 1, 0);
                gq.push_back(v);
                @(negedge clk);
                bus.gold_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("gold_push_timeout", 0, 1);
        bus.gold_valid = 1'b0;
    endtask

    task automatic send_res(input logic [W-1:0] v);
        pair_t p;
        bus.res_valid = 1'b1;
        bus.res_data  = v;
        for (int k = 0; k < 300; k++) begin
            if (bus.res_ready) begin
                if (gq.size() == 0) begin
                    check("res_ready_when_empty", 1, 0);
                end else begin
                    p.t = v;
                    p.g = gq.pop_front();
                    exq.push_back(p);
                end
                @(negedge clk);
                bus.res_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("res_send_timeout", 0, 1);
        bus.res_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        run_idx = 0;
        run_err = 0;
        @(negedge clk);
        start = 1'b0;
        check("start_clear_checked", checked_count, 0);
        check("start_clear_errors", error_count, 0);
        check("start_clear_fev", first_err_valid, 0);
        check("start_busy", busy, 1);
    endtask

    task automatic feed(input logic [W-1:0] g[NV], input logic [W-1:0] r[NV],
                        input int npre, input int start_at);
        fork
            begin
                for (int i = npre; i < NV; i++) push_gold(g[i]);
            end
            begin
                for (int i = 0; i < NV; i++) begin
                    send_res(r[i]);
                    if (i == start_at) begin
                        @(negedge clk);
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
        join
    endtask

    task automatic finish_run(input string tag, input logic [W-1:0] g[NV], input logic [W-1:0] r[NV]);
        int errs;
        int first;
        errs  = 0;
        first = 0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (r[i] != g[i]) begin
                errs++;
                first = i;
            end
        end
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, (errs == 0));
        check({tag, "_checked"}, checked_count, NV);
        check({tag, "_errors"}, error_count, errs);
        check({tag, "_fev"}, first_err_valid, (errs != 0));
        check({tag, "_first_idx"}, first_err_idx, first);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pending"}, exq.size(), 0);
    endtask

    logic [W-1:0] g[NV];
    logic [W-1:0] r[NV];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.gold_valid = 1'b0;
        bus.gold_data  = '0;
        bus.res_valid  = 1'b0;
        bus.res_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_gold_ready", bus.gold_ready, 1);
        check("rst_res_ready", bus.res_ready, 0);
        check("rst_cmp_valid", bus.cmp_valid, 0);
        check("rst_busy_done_pass", {busy, done, pass}, 0);
        check("rst_counts", {checked_count, error_count, first_err_idx}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a run with goldens still queued.
        for (int i = 0; i < 4; i++) push_gold($urandom);
        pulse_start();
        send_res($urandom);
        send_res(gq[0]);
        repeat (3) @(negedge clk);
        check("mid_checked_before_reset", checked_count, 2);
        reset = 1'b1;
        @(negedge clk);
        gq.delete();
        exq.delete();
        check("mr_gold_ready", bus.gold_ready, 1);
        check("mr_res_ready", bus.res_ready, 0);
        check("mr_cmp_busy_done_pass", {bus.cmp_valid, busy, done, pass}, 0);
        check("mr_counts", {checked_count, error_count, first_err_idx}, 0);
        check("mr_fev", first_err_valid, 0);
        check("mr_pair", {bus.test_result, bus.gold_result}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Backpressure on an empty FIFO, then a randomized run.
        for (int i = 0; i < NV; i++) begin
            g[i] = $urandom;
            r[i] = ($urandom_range(0, 3) == 0) ? (g[i] ^ ($urandom | 32'd1)) : g[i];
        end
        pulse_start();
        bus.res_valid = 1'b1;
        bus.res_data  = r[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_res_ready", bus.res_ready, 0);
            check("bp_no_cmp", bus.cmp_valid, 0);
            check("bp_busy", busy, 1);
        end
        push_gold(g[0]);
        check("bp_ready_after_push", bus.res_ready, 1);
        feed(g, r, 1, -1);
        finish_run("rand", g, r);

        // FIFO full in DONE, held 9th push, restart, start ignored mid-run.
        for (int i = 0; i < NV; i++) begin
            g[i] = W'(i);
            r[i] = W'(i);
        end
        for (int i = 0; i < D; i++) push_gold(g[i]);
        check("full_gold_ready", bus.gold_ready, 0);
        bus.gold_valid = 1'b1;
        bus.gold_data  = g[D];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_held", bus.gold_ready, 0);
        end
        pulse_start();
        feed(g, r, D, 5);
        finish_run("allmatch", g, r);

        // Two injected mismatches.
        r[3] = 32'hFFFF_FFFF;
        r[9] = 32'hFFFF_FFFF;
        pulse_start();
        feed(g, r, 0, -1);
        finish_run("mism", g, r);

        // Further random runs.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NV; i++) begin
                g[i] = $urandom;
                r[i] = ($urandom_range(0, 4) == 0) ? ~g[i] : g[i];
            end
            pulse_start();
            feed(g, r, 0, -1);
            finish_run("rand_loop", g, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
